// File: rtl/uart_tx_ctrl_pkg.sv
// Shared constants for the UART transmit path: baud divisors, rate-select codes,
// FSM state encoding and the rate-select to divisor lookup.
package uart_tx_ctrl_pkg;

   localparam logic [15:0] BPS_9600   = 16'd5207;
   localparam logic [15:0] BPS_19200  = 16'd2603;
   localparam logic [15:0] BPS_38400  = 16'd1301;
   localparam logic [15:0] BPS_57600  = 16'd867;
   localparam logic [15:0] BPS_115200 = 16'd433;

   localparam logic [2:0] SEL_9600   = 3'd0;
   localparam logic [2:0] SEL_19200  = 3'd1;
   localparam logic [2:0] SEL_38400  = 3'd2;
   localparam logic [2:0] SEL_57600  = 3'd3;
   localparam logic [2:0] SEL_115200 = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_HOLD  = 3'd4
   } tx_state_t;

   // Unused select codes fall back to the slowest rate.
   function automatic logic [15:0] baud_div(input logic [2:0] sel);
      logic [15:0] div_s;
      case (sel)
         SEL_9600:   div_s = BPS_9600;
         SEL_19200:  div_s = BPS_19200;
         SEL_38400:  div_s = BPS_38400;
         SEL_57600:  div_s = BPS_57600;
         SEL_115200: div_s = BPS_115200;
         default:    div_s = BPS_9600;
      endcase
      return div_s;
   endfunction

endpackage

// File: rtl/uart_bps_tick.sv
// Baud tick generator: counts 0..div while enabled and emits a one-cycle tick
// at the middle of each period. Shared between the TX and RX controllers.
module uart_bps_tick #(
   parameter int DIV_W = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bps_en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_r;
   logic [DIV_W-1:0] half_s;

   assign half_s = div >> 1;

   // Period counter, held at zero while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (!bps_en || (cnt_r == div)) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + DIV_W'(1);
      end
   end

   // Mid-period strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick <= 1'b0;
      end else begin
         tick <= bps_en && (cnt_r == half_s);
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmit controller: byte FIFO behind a valid/ready port, frame FSM
// and per-frame baud divisor latched when a byte leaves the FIFO.
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 13
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [2:0]                    baud_sel,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          txd,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [7:0]       mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] cnt_r;
   tx_state_t        state_r;
   tx_state_t        next_state_s;
   logic [7:0]       shift_r;
   logic [2:0]       bit_idx_r;
   logic [DIV_W-1:0] div_r;
   logic             txd_r;
   logic             busy_r;
   logic             tick_s;
   logic             bps_en_s;
   logic             push_s;
   logic             pop_s;

   assign tx_ready = (cnt_r != FULL_CNT);
   assign push_s   = tx_valid && tx_ready;
   assign pop_s    = (state_r == ST_IDLE) && (cnt_r != CNT_W'(0));
   // Enabling from the next state lets the counter start on the pop edge itself.
   assign bps_en_s = (next_state_s != ST_IDLE);
   assign txd      = txd_r;
   assign busy     = busy_r;
   assign fifo_cnt = cnt_r;

   uart_bps_tick #(.DIV_W(DIV_W)) u_bps_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .bps_en (bps_en_s),
      .div    (div_r),
      .tick   (tick_s)
   );

   // FIFO storage; contents are don't-care outside the occupied window.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= tx_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CNT_W'(1);
            2'b01:   cnt_r <= cnt_r - CNT_W'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // State register and busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s != ST_IDLE);
      end
   end

   // Frame sequencing: every bit boundary is a baud tick.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE:  if (pop_s) next_state_s = ST_START; else next_state_s = ST_IDLE;
         ST_START: if (tick_s) next_state_s = ST_DATA; else next_state_s = ST_START;
         ST_DATA:  if (tick_s && (bit_idx_r == 3'd7)) next_state_s = ST_STOP;
                   else next_state_s = ST_DATA;
         ST_STOP:  if (tick_s) next_state_s = ST_HOLD; else next_state_s = ST_STOP;
         ST_HOLD:  if (tick_s) next_state_s = ST_IDLE; else next_state_s = ST_HOLD;
         default:  next_state_s = ST_IDLE;
      endcase
   end

   // Serial datapath: load on pop, drive txd on the edge after each tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txd_r     <= 1'b1;
         shift_r   <= 8'h00;
         bit_idx_r <= 3'd0;
         div_r     <= DIV_W'(BPS_9600);
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  shift_r <= mem_r[rd_ptr_r];
                  div_r   <= DIV_W'(baud_div(baud_sel));
               end
            end
            ST_START: begin
               if (tick_s) begin
                  txd_r     <= 1'b0;
                  bit_idx_r <= 3'd0;
               end
            end
            ST_DATA: begin
               if (tick_s) begin
                  txd_r     <= shift_r[0];
                  shift_r   <= {1'b0, shift_r[7:1]};
                  bit_idx_r <= bit_idx_r + 3'd1;
               end
            end
            ST_STOP: begin
               if (tick_s) begin
                  txd_r <= 1'b1;
               end
            end
            default: begin
               txd_r <= txd_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame timing, LSB-first data, FIFO back-pressure,
// per-frame baud latching, mid-frame reset and a push coinciding with the stop-bit end.
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] baud_sel;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       txd;
   logic       busy;
   logic [2:0] fifo_cnt;

   int tests = 0;
   int fails = 0;

   uart_tx_ctrl #(.FIFO_DEPTH(4), .DIV_W(13)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .baud_sel (baud_sel),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .txd      (txd),
      .busy     (busy),
      .fifo_cnt (fifo_cnt)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Returns the number of falling clock edges until txd is seen low.
   task automatic wait_start(input int limit, output int waited);
      waited = 0;
      while ((txd !== 1'b0) && (waited < limit)) begin
         @(negedge clk);
         waited++;
      end
   endtask

   // Entered on the first cycle of the start bit; checks first and last cycle of nbits bits.
   task automatic frame_chk(input logic [7:0] data, input int len, input int nbits, input string tag);
      logic [9:0] bits_v;
      bits_v = {1'b1, data, 1'b0};
      for (int k = 0; k < nbits; k++) begin
         chk($sformatf("%s_bit%0d_first", tag, k), 32'(txd), 32'(bits_v[k]));
         repeat (len - 1) @(negedge clk);
         chk($sformatf("%s_bit%0d_last", tag, k), 32'(txd), 32'(bits_v[k]));
         @(negedge clk);
      end
      if (nbits == 10) begin
         chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int w;
      int low;

      rst_n    = 1'b0;
      baud_sel = 3'd2;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cnt", 32'(fifo_cnt), 32'd0);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // 38400 baud, 0x55: start after 650+2 clocks, 1302 clocks per bit.
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("t1_cnt_push", 32'(fifo_cnt), 32'd1);
      chk("t1_busy_push", 32'(busy), 32'd0);
      wait_start(4000, w);
      chk("t1_start_lat", 32'(w), 32'd652);
      frame_chk(8'h55, 1302, 10, "t1");
      chk("t1_cnt_end", 32'(fifo_cnt), 32'd0);

      // 115200 baud, six bytes back to back; the sixth stalls on a full FIFO.
      baud_sel = 3'd4;
      for (int i = 1; i <= 5; i++) begin
         tx_data  = 8'(i);
         tx_valid = 1'b1;
         @(negedge clk);
      end
      tx_data = 8'h06;
      chk("t2_full_ready", 32'(tx_ready), 32'd0);
      chk("t2_full_cnt", 32'(fifo_cnt), 32'd4);
      wait_start(1000, w);
      chk("t2_start_lat", 32'(w + 4), 32'd218);
      frame_chk(8'h01, 434, 10, "t2_b1");
      chk("t2_stall", 32'(tx_ready), 32'd0);
      w = 0;
      while ((tx_ready !== 1'b1) && (w < 100)) begin
         @(negedge clk);
         w++;
      end
      chk("t2_release", 32'(w), 32'd1);
      @(negedge clk);
      tx_valid = 1'b0;
      chk("t2_cnt_refill", 32'(fifo_cnt), 32'd4);
      wait_start(1000, w);
      chk("t2_gap_b2", 32'(w + 2), 32'd218);
      frame_chk(8'h02, 434, 10, "t2_b2");
      for (int b = 3; b <= 6; b++) begin
         wait_start(1000, w);
         chk($sformatf("t2_gap_b%0d", b), 32'(w), 32'd218);
         frame_chk(8'(b), 434, 10, $sformatf("t2_b%0d", b));
      end
      chk("t2_cnt_end", 32'(fifo_cnt), 32'd0);

      // Rate change 4->7 after 0x3C is popped: 0x3C stays at 434, 0xA3 runs at 5208.
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      @(negedge clk);
      baud_sel = 3'd7;
      tx_data  = 8'hA3;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data  = 8'h77;
      @(negedge clk);
      tx_data  = 8'h88;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("t3_cnt_queued", 32'(fifo_cnt), 32'd3);
      chk("t3_busy", 32'(busy), 32'd1);
      wait_start(1000, w);
      chk("t3_start_lat", 32'(w + 4), 32'd218);
      frame_chk(8'h3C, 434, 10, "t3_3c");
      wait_start(4000, w);
      chk("t3_gap_new_rate", 32'(w), 32'd2605);
      frame_chk(8'hA3, 5208, 4, "t3_a3");
      repeat (100) @(negedge clk);
      chk("t3_a3_bit4", 32'(txd), 32'd0);
      chk("t3_cnt_pre_rst", 32'(fifo_cnt), 32'd2);

      // Asynchronous reset inside the fourth data bit with two bytes queued.
      rst_n = 1'b0;
      #1;
      chk("t5_rst_txd", 32'(txd), 32'd1);
      chk("t5_rst_cnt", 32'(fifo_cnt), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_ready", 32'(tx_ready), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      low = 0;
      repeat (3000) begin
         @(negedge clk);
         if (txd !== 1'b1) low++;
      end
      chk("t5_no_frame", 32'(low), 32'd0);
      chk("t5_idle_busy", 32'(busy), 32'd0);

      // Push landing exactly on the HOLD tick edge with the FIFO empty.
      baud_sel = 3'd4;
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      wait_start(1000, w);
      chk("t6_start_lat", 32'(w), 32'd218);
      frame_chk(8'h5A, 434, 9, "t6_5a");
      chk("t6_stop_first", 32'(txd), 32'd1);
      repeat (433) @(negedge clk);
      chk("t6_busy_pre", 32'(busy), 32'd1);
      tx_data  = 8'hC7;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      chk("t6_busy_hold", 32'(busy), 32'd0);
      chk("t6_cnt_hold", 32'(fifo_cnt), 32'd1);
      wait_start(1000, w);
      chk("t6_gap", 32'(w), 32'd218);
      frame_chk(8'hC7, 434, 10, "t6_c7");
      chk("t6_cnt_end", 32'(fifo_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
